// File: rtl/rf_wb_sched_if.sv
// Write-request bundle for the RF write-port scheduler: in-order pipeline
// writeback (source A) and the buffered MDU result stream (source B).
interface rf_wb_sched_if;
  logic        a_we;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [31:0] a_pc;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [31:0] b_pc;

  modport master (
    output a_we, a_addr, a_data, a_pc,
    output b_valid, b_addr, b_data, b_pc,
    input  b_ready
  );

  modport slave (
    input  a_we, a_addr, a_data, a_pc,
    input  b_valid, b_addr, b_data, b_pc,
    output b_ready
  );
endinterface

// File: rtl/rf_wb_sched.sv
// Shares the single RF write port between pipeline writeback and buffered MDU
// results, tracks pending MDU destinations and stalls decode on hazards.
module rf_wb_sched #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  rf_wb_sched_if.slave bus,
  input  logic         sb_set,
  input  logic [4:0]   sb_addr,
  input  logic [4:0]   rs_addr,
  input  logic [4:0]   rt_addr,
  output logic         stall,
  output logic         hold_a,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [31:0]  rf_wdata,
  output logic [31:0]  rf_pc,
  output logic [31:0]  busy_vec,
  output logic         err_waw
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } b_entry_t;

  b_entry_t        mem [DEPTH];
  b_entry_t        head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  logic            src_b;
  logic            full, empty, push;
  logic            a_ok, grant_a, grant_b, b_write;
  logic [31:0]     busy_next;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // b_ready is gated by reset so the MDU sees no acceptance while in reset.
  assign bus.b_ready = reset && !full;
  assign push        = bus.b_valid && bus.b_ready;

  assign a_ok    = bus.a_we && (bus.a_addr != 5'd0);
  assign hold_a  = (starve_cnt == SW'(STARVE_MAX)) && !empty;
  assign grant_b = !empty && (hold_a || !a_ok);
  assign grant_a = a_ok && !hold_a;
  assign b_write = grant_b && (head.addr != 5'd0);

  // NOTE: the result storage has no reset; pointers and count define validity,
  // so clearing the array would only add reset fan-out for no behaviour.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: bus.b_addr, data: bus.b_data, pc: bus.b_pc};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (grant_b) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, grant_b})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (empty || grant_b)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      src_b    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_pc    <= '0;
    end else begin
      rf_we <= grant_a || b_write;
      src_b <= b_write;
      if (grant_a) begin
        rf_waddr <= bus.a_addr;
        rf_wdata <= bus.a_data;
        rf_pc    <= bus.a_pc;
      end else if (b_write) begin
        rf_waddr <= head.addr;
        rf_wdata <= head.data;
        rf_pc    <= head.pc;
      end
    end
  end

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    busy_next = busy_vec;
    if (rf_we && src_b) busy_next[rf_waddr] = 1'b0;
    // Set follows clear so a same-edge set on the committing register wins.
    if (sb_set && sb_addr != 5'd0) busy_next[sb_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_vec <= '0;
      err_waw  <= 1'b0;
    end else begin
      busy_vec <= busy_next;
      if (a_ok && busy_vec[bus.a_addr] && !hold_a) err_waw <= 1'b1;
    end
  end

  assign stall = (rs_addr != 5'd0 && busy_vec[rs_addr]) ||
                 (rt_addr != 5'd0 && busy_vec[rt_addr]) ||
                 (sb_set && sb_addr != 5'd0 && busy_vec[sb_addr]);

endmodule
